mem_dual_ctrl: RTL and testbench
================================

Name: mem_dual_ctrl

Overview:
Controller for one dual-port activation/weight memory: 1 synchronous write port, 1 asynchronous read port, DEPTH x BIT_SIZE.
- Write side: round-robin arbitration between NUM_REQ writers (e.g. neuron output lanes) onto the single write port, with a registered write stage.
- Read side: a start/length sequencer streams memory contents out over a valid/ready interface.
- Sits between the neuron array and the memory macro; the memory itself is instantiated outside this block.

Parameters:
DEPTH, 16, memory words; must be >= 2; AW = $clog2(DEPTH)
BIT_SIZE, 16, word width in bits
NUM_REQ, 4, number of write requesters; must be >= 2

Ports:
clk  in  1  clock, all state on posedge
rst_n  in  1  asynchronous active-low reset
wr_valid  in  NUM_REQ  per-requester write request
wr_addr  in  NUM_REQ*AW  packed addresses; requester i at [i*AW +: AW]
wr_data  in  NUM_REQ*BIT_SIZE  packed data; requester i at [i*BIT_SIZE +: BIT_SIZE]
wr_ready  out  NUM_REQ  one-hot grant; a beat is accepted when wr_valid[i] && wr_ready[i]
mem_we  out  1  to memory write_enable
mem_waddr  out  AW  to memory write_addr
mem_wdata  out  BIT_SIZE  to memory data_in
mem_raddr  out  AW  to memory read_addr
mem_rdata  in  BIT_SIZE  from memory data_out (combinational read)
start  in  1  one-cycle pulse; begins a read stream
base_addr  in  AW  first read address, sampled on start
length  in  AW+1  beat count 0..DEPTH, sampled on start
busy  out  1  high in STREAM
done  out  1  one-cycle pulse at stream end
rd_valid  out  1  stream beat valid
rd_data  out  BIT_SIZE  stream beat data
rd_ready  in  1  downstream ready

Behaviour:
Reset values:
- Outputs: wr_ready=0, mem_we=0, mem_waddr=0, mem_wdata=0, mem_raddr=0, busy=0, done=0, rd_valid=0, rd_data=mem_rdata.
- Internal: rr pointer=0, state=IDLE.
- Reset mid-stream aborts the stream; no done pulse.

Write arbiter:
- wr_ready is combinational: the first i with wr_valid[i] set, searching from rr pointer upward with wrap.
- All wr_valid low -> wr_ready=0.
- On an accepted beat from requester g:
  - rr pointer <= (g+1) mod NUM_REQ.
  - mem_we/mem_waddr/mem_wdata are registered from requester g at that edge.
- Otherwise mem_we <= 0; mem_waddr and mem_wdata hold.
- Latency: beat accepted at edge k -> mem_we high in cycle k+1 -> memory written at edge k+1.
- Throughput: 1 write per cycle.
- A requester holding wr_valid waits at most NUM_REQ-1 grants.

Read sequencer FSM (IDLE, STREAM, DONE):
- IDLE:
  - start with length != 0 -> STREAM; latch ptr=base_addr, cnt=length.
  - start with length == 0 -> DONE; no beats.
- STREAM:
  - busy=1; mem_raddr=ptr; rd_data=mem_rdata.
  - rd_valid=1 unless hazard (below).
  - On rd_valid && rd_ready: ptr <= (ptr+1) mod DEPTH (wraps DEPTH-1 -> 0), cnt <= cnt-1.
  - Beat with cnt==1 -> DONE.
- DONE: done=1 for exactly one cycle -> IDLE.
- start is ignored in STREAM and DONE.
- In IDLE, mem_raddr holds its last value.
- rd_valid, once high, stays high until the handshake completes; the hazard check is evaluated only before rd_valid rises for a beat.

Read-after-write hazard:
- Condition: mem_we && mem_waddr == ptr in STREAM, i.e. the read would return stale data.
- Response: rd_valid=0 that cycle; rd_valid rises the next cycle with the new data.
- Writes never stall for reads.
- Arbitration is independent of the stream.

Optional Feature:
Macro MEM_CTRL_WR_BYPASS_EN.
- Defined: no hazard stall. When the hazard condition holds, rd_data=mem_wdata and rd_valid=1.
- Undefined: the one-cycle stall above.
- Both builds must produce identical beat data sequences.

Decomposition:
- Package mem_ctrl_pkg holds:
  - rd_state_t enum {IDLE, STREAM, DONE}
  - function rr_pick(valid, ptr) returning the one-hot grant
- Sub-module rr_arbiter #(N) (wr_valid, ptr in; one-hot grant out; purely combinational) is natural.
- The rr pointer register stays in mem_dual_ctrl.

Test Plan:
1. Reset: rst_n low mid-stream (after 3 of 8 beats) -> all outputs at reset values immediately; state IDLE; no done pulse.
2. Round-robin fairness: all 4 wr_valid held high for 8 cycles -> grant order 0,1,2,3,0,1,2,3; each mem_we one cycle after the corresponding grant with the matching addr/data.
3. Stream with wrap: DEPTH=16, base_addr=14, length=4, memory preloaded mem[a]=a -> beats 14,15,0,1; done one cycle after the last beat; busy low thereafter.
4. Backpressure and zero length: rd_ready toggles 1,0,0,1 -> no beat lost or duplicated. start with length=0 -> done pulse next cycle, rd_valid never asserts.
5. RAW hazard: requester 2 writes 0xBEEF to address 5 in the cycle before the stream reaches ptr=5. Without the macro -> rd_valid low for 1 cycle, then beat 0xBEEF. With MEM_CTRL_WR_BYPASS_EN -> 0xBEEF with no stall.
6. start while busy: start pulse during STREAM -> ignored; the original length and base complete unchanged.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and the round-robin pick helper for the dual-port memory controller.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, STREAM, DONE} rd_state_t;

    localparam int MAX_REQ = 32;

    // First set bit of valid at or above ptr, wrapping at n.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input int unsigned        ptr,
        input int unsigned        n
    );
        logic [MAX_REQ-1:0] grant;
        logic               found;
        int unsigned        idx;
        grant = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            if (k < n) begin
                idx = (ptr + k) % n;
                if (!found && valid[idx[4:0]]) begin
                    grant[idx[4:0]] = 1'b1;
                    found = 1'b1;
                end
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/mem_dual_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant from request vector and priority pointer.
module rr_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int N = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic [MAX_REQ-1:0] valid_ext;
    logic [MAX_REQ-1:0] pick;

    always_comb begin
        valid_ext = '0;
        valid_ext[N-1:0] = valid;
        pick = rr_pick(valid_ext, 32'(ptr), 32'(N));
        grant = pick[N-1:0];
    end

    if (N < MAX_REQ) begin : g_pad
        logic unused_hi;
        assign unused_hi = ^pick[MAX_REQ-1:N];
    end

endmodule

// File: rtl/mem_dual_ctrl.sv
// Dual-port memory controller: round-robin write arbitration plus a start/length read streamer.
// Define MEM_CTRL_WR_BYPASS_EN to forward in-flight write data instead of stalling on read-after-write.
module mem_dual_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int BIT_SIZE = 16,
    parameter int NUM_REQ  = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           wr_valid,
    input  logic [NUM_REQ*AW-1:0]        wr_addr,
    input  logic [NUM_REQ*BIT_SIZE-1:0]  wr_data,
    output logic [NUM_REQ-1:0]           wr_ready,
    output logic                         mem_we,
    output logic [AW-1:0]                mem_waddr,
    output logic [BIT_SIZE-1:0]          mem_wdata,
    output logic [AW-1:0]                mem_raddr,
    input  logic [BIT_SIZE-1:0]          mem_rdata,
    input  logic                         start,
    input  logic [AW-1:0]                base_addr,
    input  logic [AW:0]                  length,
    output logic                         busy,
    output logic                         done,
    output logic                         rd_valid,
    output logic [BIT_SIZE-1:0]          rd_data,
    input  logic                         rd_ready
);

    localparam int PW = $clog2(NUM_REQ);

    logic [PW-1:0]      rr_ptr;
    logic [NUM_REQ-1:0] grant;
    logic [PW-1:0]      gidx;
    logic               accept;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .valid (wr_valid),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    // Grant is forced low while reset is asserted.
    assign wr_ready = rst_n ? grant : '0;
    assign accept   = |(wr_valid & grant);

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) gidx = PW'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= accept;
            if (accept) begin
                rr_ptr    <= (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
                mem_waddr <= wr_addr[int'(gidx)*AW +: AW];
                mem_wdata <= wr_data[int'(gidx)*BIT_SIZE +: BIT_SIZE];
            end
        end
    end

    rd_state_t        state;
    rd_state_t        nstate;
    logic [AW-1:0]    ptr;
    logic [AW:0]      cnt;
    logic             hold;
    logic             hazard;
    logic             beat;

    assign mem_raddr = ptr;
    assign hazard    = (state == STREAM) && mem_we && (mem_waddr == ptr);
    assign beat      = rd_valid && rd_ready;
    assign done      = (state == DONE);

    always_comb begin
        nstate   = state;
        busy     = 1'b0;
        rd_valid = 1'b0;
        rd_data  = mem_rdata;
        unique case (state)
            IDLE: begin
                if (start) nstate = (length != '0) ? STREAM : DONE;
            end
            STREAM: begin
                busy = 1'b1;
`ifdef MEM_CTRL_WR_BYPASS_EN
                rd_valid = 1'b1;
                if (hazard && !hold) rd_data = mem_wdata;
`else
                // A beat already on the bus is never withdrawn.
                rd_valid = hold || !hazard;
`endif
                if (rd_valid && rd_ready && cnt == (AW+1)'(1)) nstate = DONE;
            end
            DONE: nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            cnt   <= '0;
            hold  <= 1'b0;
        end else begin
            state <= nstate;
            hold  <= rd_valid && !rd_ready;
            if (state == IDLE && start && length != '0) begin
                ptr <= base_addr;
                cnt <= length;
            end else if (beat) begin
                cnt <= cnt - 1'b1;
                // Address stays on the last beat once the stream ends.
                if (cnt != (AW+1)'(1))
                    ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_dual_ctrl.sv
// Self-checking bench for mem_dual_ctrl with a behavioural memory and arbitration model.
module tb_mem_dual_ctrl;

    localparam int DEPTH = 16;
    localparam int BS    = 16;
    localparam int NR    = 4;
    localparam int AW    = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR-1:0]    wr_valid;
    logic [NR*AW-1:0] wr_addr;
    logic [NR*BS-1:0] wr_data;
    logic [NR-1:0]    wr_ready;
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [BS-1:0]    mem_wdata;
    logic [AW-1:0]    mem_raddr;
    logic [BS-1:0]    mem_rdata;
    logic             start;
    logic [AW-1:0]    base_addr;
    logic [AW:0]      length;
    logic             busy;
    logic             done;
    logic             rd_valid;
    logic [BS-1:0]    rd_data;
    logic             rd_ready;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_dual_ctrl #(.DEPTH(DEPTH), .BIT_SIZE(BS), .NUM_REQ(NR)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_ready  (rd_ready)
    );

    // Memory macro stand-in: synchronous write, combinational read.
    logic [BS-1:0] mem [DEPTH];
    always @(posedge clk) if (mem_we) mem[mem_waddr] <= mem_wdata;
    assign mem_rdata = mem[mem_raddr];

    // Reference: what memory should hold once every accepted write lands.
    logic [BS-1:0] shadow [DEPTH];

    // Reference round-robin: first requester at or after the priority index.
    int exp_rr;
    function automatic int model_pick(input logic [NR-1:0] v, input int p);
        for (int k = 0; k < NR; k++)
            if (v[(p + k) % NR]) return (p + k) % NR;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_rr <= 0;
        else if (wr_valid != '0) exp_rr <= (model_pick(wr_valid, exp_rr) + 1) % NR;
    end

    task automatic test_reset;
        int beats;
        rst_n = 1'b0; start = 1'b0; rd_ready = 1'b0;
        base_addr = '0; length = '0;
        wr_valid = 4'hF; wr_addr = 16'($urandom); wr_data = {$urandom, $urandom};
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({wr_ready, mem_we, mem_waddr, mem_wdata, mem_raddr, busy, done, rd_valid} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%h we=%b wa=%h wd=%h ra=%h busy=%b done=%b v=%b, expected all zero",
                     wr_ready, mem_we, mem_waddr, mem_wdata, mem_raddr, busy, done, rd_valid);
        end
        @(negedge clk); rst_n = 1'b1; wr_valid = '0;
        @(negedge clk); start = 1'b1; base_addr = 4'd0; length = 5'd8; rd_ready = 1'b1;
        @(negedge clk); start = 1'b0;
        beats = 0;
        for (int c = 0; c < 20 && beats < 3; c++) begin
            #1;
            if (rd_valid && rd_ready) beats++;
            @(negedge clk);
        end
        checks++;
        if (beats != 3 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_prestream: got beats=%0d busy=%b, expected 3 and 1", beats, busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, rd_valid, done, mem_raddr, mem_we, wr_ready} !== '0) begin
            errors++;
            $display("FAIL reset_midstream: got busy=%b v=%b done=%b ra=%h we=%b, expected all zero",
                     busy, rd_valid, done, mem_raddr, mem_we);
        end
        @(negedge clk); rst_n = 1'b1; rd_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_done: got done=%b busy=%b, expected 0 0", done, busy);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_round_robin;
        logic          exp_we;
        logic [AW-1:0] exp_a;
        logic [BS-1:0] exp_d;
        logic [NR-1:0] eg;
        int            g;
        exp_we = 1'b0; exp_a = '0; exp_d = '0;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            checks++;
            if ({mem_we, mem_waddr, mem_wdata} !== {exp_we, exp_a, exp_d}) begin
                errors++;
                $display("FAIL wr_stage: got we=%b a=%h d=%h, expected we=%b a=%h d=%h",
                         mem_we, mem_waddr, mem_wdata, exp_we, exp_a, exp_d);
            end
            wr_valid = (i < 8) ? 4'hF : 4'($urandom);
            wr_addr  = 16'($urandom);
            wr_data  = {$urandom, $urandom};
            #1;
            g  = model_pick(wr_valid, exp_rr);
            eg = (g < 0) ? '0 : 4'(1 << g);
            if (i < 8) eg = 4'(1 << (i % NR));
            checks++;
            if (wr_ready !== eg) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got %b, expected %b", i, wr_ready, eg);
            end
            exp_we = (g >= 0);
            if (g >= 0) begin
                exp_a = wr_addr[g*AW +: AW];
                exp_d = wr_data[g*BS +: BS];
            end
        end
        @(negedge clk);
        checks++;
        if ({mem_we, mem_waddr, mem_wdata} !== {exp_we, exp_a, exp_d}) begin
            errors++;
            $display("FAIL wr_stage_last: got we=%b a=%h d=%h, expected we=%b a=%h d=%h",
                     mem_we, mem_waddr, mem_wdata, exp_we, exp_a, exp_d);
        end
        wr_valid = '0;
    endtask

    task automatic preload(input int rnd);
        logic [BS-1:0] v;
        for (int a = 0; a < DEPTH; a++) begin
            @(negedge clk);
            v = rnd ? 16'($urandom) : 16'(a);
            wr_valid = 4'(1 << (a % NR));
            wr_addr  = '0;
            wr_data  = '0;
            wr_addr[(a % NR)*AW +: AW] = 4'(a);
            wr_data[(a % NR)*BS +: BS] = v;
            shadow[a] = v;
        end
        @(negedge clk); wr_valid = '0;
        @(negedge clk);
    endtask

    // pat: 0 always ready, 1 ready pattern 1,0,0,1, 2 random ready.
    task automatic run_stream(input int base, input int len, input int pat, input int wcyc,
                              input logic [AW-1:0] waddr, input logic [BS-1:0] wdat,
                              input int inj, output int stalls);
        int beats, last_beat;
        logic prv_v, prv_r, fin;
        logic [BS-1:0] expd;
        beats = 0; last_beat = -1; stalls = 0;
        prv_v = 1'b0; prv_r = 1'b0; fin = 1'b0;
        @(negedge clk);
        start = 1'b1; base_addr = 4'(base); length = 5'(len); rd_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 80 && !fin; cyc++) begin
            case (pat)
                0: rd_ready = 1'b1;
                1: rd_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rd_ready = 1'($urandom);
            endcase
            if (inj != 0 && cyc == 1) begin
                start = 1'b1; base_addr = 4'(base + 7); length = 5'd3;
            end else begin
                start = 1'b0; base_addr = 4'($urandom); length = 5'($urandom);
            end
            wr_valid = '0;
            if (cyc == wcyc) begin
                wr_valid = 4'b0100;
                wr_addr[2*AW +: AW] = waddr;
                wr_data[2*BS +: BS] = wdat;
            end
            #1;
            if (busy && !rd_valid) stalls++;
            checks++;
            if (rd_valid && !busy) begin
                errors++;
                $display("FAIL valid_outside_stream: got v=%b busy=%b, expected v=0", rd_valid, busy);
            end
            if (prv_v && !prv_r) begin
                checks++;
                if (!rd_valid) begin
                    errors++;
                    $display("FAIL valid_dropped: got v=%b, expected 1", rd_valid);
                end
            end
            if (rd_valid && rd_ready) begin
                expd = shadow[(base + beats) % DEPTH];
                checks++;
                if (beats >= len || rd_data !== expd) begin
                    errors++;
                    $display("FAIL beat[%0d]: got %h, expected %h (len %0d)", beats, rd_data, expd, len);
                end
                beats++;
                last_beat = cyc;
            end
            if (cyc == wcyc) begin
                checks++;
                if (wr_ready !== 4'b0100) begin
                    errors++;
                    $display("FAIL inject_grant: got %b, expected 0100", wr_ready);
                end
                shadow[waddr] = wdat;
            end
            if (done) begin
                fin = 1'b1;
                checks++;
                if (cyc != last_beat + 1 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL done_timing: got cycle %0d busy=%b, expected cycle %0d busy=0",
                             cyc, busy, last_beat + 1);
                end
            end
            prv_v = rd_valid; prv_r = rd_ready;
            @(negedge clk);
        end
        start = 1'b0; wr_valid = '0; rd_ready = 1'b0;
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL stream_timeout: got no done, expected done within 80 cycles");
        end else begin
            #1;
            checks++;
            if ({done, busy, rd_valid} !== 3'b000) begin
                errors++;
                $display("FAIL after_done: got done=%b busy=%b v=%b, expected 0 0 0", done, busy, rd_valid);
            end
            if (beats != len) begin
                errors++;
                $display("FAIL beat_count: got %0d, expected %0d", beats, len);
            end
        end
    endtask

    task automatic test_stream_wrap;
        int st;
        preload(0);
        run_stream(14, 4, 0, -1, '0, '0, 0, st);
        checks++;
        if (st != 0) begin
            errors++;
            $display("FAIL wrap_stalls: got %0d, expected 0", st);
        end
    endtask

    task automatic test_backpressure;
        int st;
        preload(1);
        run_stream(2, 5, 1, -1, '0, '0, 0, st);
        run_stream(9, 16, 2, -1, '0, '0, 0, st);
        run_stream(5, 0, 0, -1, '0, '0, 0, st);
    endtask

    task automatic test_hazard;
        int st, exp_st;
        preload(0);
        run_stream(3, 4, 0, 1, 4'd5, 16'hBEEF, 0, st);
`ifdef MEM_CTRL_WR_BYPASS_EN
        exp_st = 0;
`else
        exp_st = 1;
`endif
        checks++;
        if (st != exp_st) begin
            errors++;
            $display("FAIL raw_stall: got %0d stall cycles, expected %0d", st, exp_st);
        end
    endtask

    task automatic test_start_busy;
        int st;
        preload(1);
        run_stream(10, 6, 0, -1, '0, '0, 1, st);
    endtask

    task automatic test_random_streams;
        int st, b, l;
        for (int n = 0; n < 6; n++) begin
            b = int'($urandom_range(0, DEPTH - 1));
            l = int'($urandom_range(1, DEPTH));
            run_stream(b, l, 0, int'($urandom_range(0, 5)),
                       4'(b + int'($urandom_range(0, 5))), 16'($urandom), 0, st);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_stream_wrap();
        test_backpressure();
        test_hazard();
        test_start_busy();
        test_random_streams();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
